// File: rtl/am2954_busctl.sv
`default_nettype none
// ============================================================================
// Module   : am2954_busctl
// Purpose  : Round-robin bus controller for a bank of am2954-style tristate
//            octal registers sharing one data bus. Grants one requester at a
//            time, drives the registers' active-low output enables and load
//            strobes for one DRIVE cycle, and returns a one-cycle acknowledge.
//            At most one output enable is ever low.
// Option   : BUSCTL_TURNAROUND_EN - when defined, every DRIVE cycle is
//            followed by one TURN cycle with the bus undriven. When undefined
//            DRIVE cycles may run back-to-back.
// Ports    : i_cp     clock, rising edge
//            i_reset  synchronous active-high reset
//            i_req    [NREQ]     request per requester, held until ack
//            i_src    [NREQ*SW]  source register index, requester i at [i*SW +: SW]
//            i_dst    [NREQ*SW]  destination register index, same packing
//            o_ack    [NREQ]     one-cycle acknowledge (the transfer cycle)
//            o_oe_    [NREG]     active-low output enables to the registers
//            o_ld     [NREG]     load strobes, destination captures at cycle end
//            o_busy              high in any non-IDLE state
// Revision : 1.0 - initial release
// ============================================================================
module am2954_busctl #(
  parameter int NREQ = 3,
  parameter int NREG = 4,
  parameter int SW   = 2
) (
  input  logic                 i_cp,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*SW-1:0]   i_src,
  input  logic [NREQ*SW-1:0]   i_dst,
  output logic [NREQ-1:0]      o_ack,
  output logic [NREG-1:0]      o_oe_,
  output logic [NREG-1:0]      o_ld,
  output logic                 o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
`ifdef BUSCTL_TURNAROUND_EN
  localparam logic [1:0] S_TURN  = 2'd2;
`endif

  logic [1:0]            r_state;
  logic [PW-1:0]         r_ptr;
  logic [NREQ-1:0]       r_ack;
  logic [NREG-1:0]       r_oe_;
  logic [NREG-1:0]       r_ld;
  logic                  r_busy;

  logic [1:0]            w_state_nxt;
  logic                  w_grant;
  logic                  w_found;
  logic [PW-1:0]         w_idx;
  logic [PW-1:0]         w_ptr_nxt;
  logic [(1<<PW)-1:0]    w_elig;
  logic [PW:0]           w_sum;
  logic [SW-1:0]         w_src_sel;
  logic [SW-1:0]         w_dst_sel;
  logic [NREQ-1:0]       w_ack_nxt;
  logic [NREG-1:0]       w_oe_nxt;
  logic [NREG-1:0]       w_ld_nxt;

  // --------------------------------------------------------------------------
  // Round-robin arbitration. The requester being acknowledged this cycle is
  // masked out so it can drop req at the end of its ack cycle without being
  // granted a second time. The eligibility vector is padded to a power of two
  // so it can be indexed directly by a PW-bit position.
  // --------------------------------------------------------------------------
  always_comb begin
    w_elig             = '0;
    w_elig[NREQ-1:0]   = i_req & ~r_ack;
    w_found            = 1'b0;
    w_idx              = '0;
    w_sum              = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      if (!w_found && w_elig[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[PW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == PW'(NREQ-1)) ? '0 : w_idx + 1'b1;

  // Winner's source / destination indices, taken straight from the inputs at
  // the grant edge; the registered outputs hold them for the DRIVE cycle.
  always_comb begin
    w_src_sel = '0;
    w_dst_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == PW'(k)) begin
        w_src_sel = i_src[k*SW +: SW];
        w_dst_sel = i_dst[k*SW +: SW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge i_cp) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ack   <= '0;
      r_oe_   <= '1;
      r_ld    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= w_ptr_nxt;
      end
      r_ack   <= w_ack_nxt;
      r_oe_   <= w_oe_nxt;
      r_ld    <= w_ld_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Entering DRIVE always coincides with a grant.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = S_IDLE;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
`ifdef BUSCTL_TURNAROUND_EN
        w_state_nxt = S_TURN;
`else
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_DRIVE;
        end
`endif
      end
`ifdef BUSCTL_TURNAROUND_EN
      S_TURN: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode for the next cycle: a single oe_ low and a single ld high
  // only on a grant; every other case leaves the bus undriven.
  // --------------------------------------------------------------------------
  always_comb begin
    w_oe_nxt  = '1;
    w_ld_nxt  = '0;
    w_ack_nxt = '0;
    if (w_grant) begin
      w_oe_nxt[w_src_sel] = 1'b0;
      w_ld_nxt[w_dst_sel] = 1'b1;
      w_ack_nxt[w_idx]    = 1'b1;
    end
  end

  assign o_ack  = r_ack;
  assign o_oe_  = r_oe_;
  assign o_ld   = r_ld;
  assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_am2954_busctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2954_busctl
// Purpose  : Directed self-checking bench for am2954_busctl (NREQ=3, NREG=4).
//            Each step drives inputs, queues the outputs expected after the
//            next rising edge, then pops and compares them. A separate monitor
//            checks that no more than one output enable is low in any cycle.
//            Honours BUSCTL_TURNAROUND_EN to select the expected sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am2954_busctl;

`ifdef BUSCTL_TURNAROUND_EN
  localparam logic TA = 1'b1;
`else
  localparam logic TA = 1'b0;
`endif

  logic       i_cp = 1'b0;
  logic       i_reset;
  logic [2:0] i_req;
  logic [5:0] i_src;
  logic [5:0] i_dst;
  logic [2:0] o_ack;
  logic [3:0] o_oe_;
  logic [3:0] o_ld;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] ld;
    logic [2:0] ack;
    logic       busy;
  } exp_t;

  exp_t  sb[$];
  string tags[$];

  am2954_busctl #(.NREQ(3), .NREG(4), .SW(2)) dut (
    .i_cp    (i_cp),
    .i_reset (i_reset),
    .i_req   (i_req),
    .i_src   (i_src),
    .i_dst   (i_dst),
    .o_ack   (o_ack),
    .o_oe_   (o_oe_),
    .o_ld    (o_ld),
    .o_busy  (o_busy)
  );

  always #5 i_cp = ~i_cp;

  function automatic logic [3:0] OE(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  function automatic logic [3:0] LD(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return one << r;
  endfunction

  function automatic logic [2:0] AK(input int i);
    logic [2:0] one;
    one = 3'b001;
    return one << i;
  endfunction

  // Bus exclusivity in every cycle, sampled away from the rising edge.
  always @(negedge i_cp) begin
    if (mon_en) begin
      n_checks++;
      assert ($countones(~o_oe_) <= 1) else begin
        n_errors++;
        $error("FAIL oe_onehot observed %b required at most one low", o_oe_);
      end
    end
  end

  task automatic step(input logic rst, input logic [2:0] rq,
                      input logic [5:0] s, input logic [5:0] d,
                      input logic [3:0] eoe, input logic [3:0] eld,
                      input logic [2:0] eack, input logic ebusy,
                      input string tag);
    exp_t  e;
    string t;
    i_reset = rst;
    i_req   = rq;
    i_src   = s;
    i_dst   = d;
    sb.push_back('{eoe, eld, eack, ebusy});
    tags.push_back(tag);
    @(posedge i_cp);
    #1;
    mon_en = 1'b1;
    e = sb.pop_front();
    t = tags.pop_front();
    n_checks++;
    assert (o_oe_ === e.oe) else begin
      n_errors++;
      $error("FAIL %s oe_ observed %b expected %b", t, o_oe_, e.oe);
    end
    n_checks++;
    assert (o_ld === e.ld) else begin
      n_errors++;
      $error("FAIL %s ld observed %b expected %b", t, o_ld, e.ld);
    end
    n_checks++;
    assert (o_ack === e.ack) else begin
      n_errors++;
      $error("FAIL %s ack observed %b expected %b", t, o_ack, e.ack);
    end
    n_checks++;
    assert (o_busy === e.busy) else begin
      n_errors++;
      $error("FAIL %s busy observed %b expected %b", t, o_busy, e.busy);
    end
  endtask

  // Operand sets, packed {req2, req1, req0}
  localparam logic [5:0] S_X1 = 6'b00_10_00;  // src1=2
  localparam logic [5:0] D_X1 = 6'b00_00_00;  // dst1=0
  localparam logic [5:0] S_RR = 6'b00_11_01;  // src0=1 src1=3 src2=0
  localparam logic [5:0] D_RR = 6'b11_00_10;  // dst0=2 dst1=0 dst2=3
  localparam logic [5:0] S_SF = 6'b00_00_11;  // src0=3
  localparam logic [5:0] D_SF = 6'b00_00_11;  // dst0=3
  localparam logic [5:0] S_WD = 6'b01_10_00;  // src1=2 src2=1
  localparam logic [5:0] D_WD = 6'b11_01_00;  // dst1=1 dst2=3

  initial begin
    i_reset = 1'b1;
    i_req   = '0;
    i_src   = '0;
    i_dst   = '0;

    // Reset then idle
    step(1, 3'b000, 0, 0, 4'hF, 4'h0, 3'b000, 0, "rst_a");
    step(1, 3'b000, 0, 0, 4'hF, 4'h0, 3'b000, 0, "rst_b");
    step(0, 3'b000, 0, 0, 4'hF, 4'h0, 3'b000, 0, "idle_a");

    // Single transfer; req1 held through its ack cycle must not re-grant
    step(0, 3'b010, S_X1, D_X1, OE(2), LD(0), AK(1), 1, "xfer_drive");
    step(0, 3'b010, S_X1, D_X1, 4'hF, 4'h0, 3'b000, TA, "xfer_after");
    step(0, 3'b000, S_X1, D_X1, 4'hF, 4'h0, 3'b000, 0, "xfer_idle");

    // Round-robin from ptr=0: order 0,1,2,0
    step(1, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 0, "rr_rst");
`ifdef BUSCTL_TURNAROUND_EN
    step(0, 3'b111, S_RR, D_RR, OE(1), LD(2), AK(0), 1, "rr_g0");
    step(0, 3'b111, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 1, "rr_t0");
    step(0, 3'b110, S_RR, D_RR, OE(3), LD(0), AK(1), 1, "rr_g1");
    step(0, 3'b111, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 1, "rr_t1");
    step(0, 3'b101, S_RR, D_RR, OE(0), LD(3), AK(2), 1, "rr_g2");
    step(0, 3'b111, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 1, "rr_t2");
    step(0, 3'b011, S_RR, D_RR, OE(1), LD(2), AK(0), 1, "rr_g0b");
    step(0, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 1, "rr_t3");
    step(0, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 0, "rr_end");
`else
    step(0, 3'b111, S_RR, D_RR, OE(1), LD(2), AK(0), 1, "rr_g0");
    step(0, 3'b111, S_RR, D_RR, OE(3), LD(0), AK(1), 1, "rr_g1");
    step(0, 3'b110, S_RR, D_RR, OE(0), LD(3), AK(2), 1, "rr_g2");
    step(0, 3'b101, S_RR, D_RR, OE(1), LD(2), AK(0), 1, "rr_g0b");
    step(0, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 0, "rr_end");
`endif

    // Self-transfer (ptr=1, only req0 up): oe_ 0111 with ld 1000
    step(0, 3'b001, S_SF, D_SF, 4'b0111, 4'b1000, AK(0), 1, "self");
    step(0, 3'b000, S_SF, D_SF, 4'hF, 4'h0, 3'b000, TA, "self_after");
    step(0, 3'b000, S_SF, D_SF, 4'hF, 4'h0, 3'b000, 0, "self_idle");

    // Withdrawal: req2 loses to req1 (ptr=1) and drops before any grant
    step(0, 3'b110, S_WD, D_WD, OE(2), LD(1), AK(1), 1, "wd_g1");
    step(0, 3'b010, S_WD, D_WD, 4'hF, 4'h0, 3'b000, TA, "wd_after");
    step(0, 3'b000, S_WD, D_WD, 4'hF, 4'h0, 3'b000, 0, "wd_idle");
    step(0, 3'b000, S_WD, D_WD, 4'hF, 4'h0, 3'b000, 0, "wd_idle2");

    // Reset during DRIVE aborts; pointer returns to requester 0
    step(0, 3'b010, S_WD, D_WD, OE(2), LD(1), AK(1), 1, "mid_g1");
    step(1, 3'b111, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 0, "mid_rst");
    step(0, 3'b111, S_RR, D_RR, OE(1), LD(2), AK(0), 1, "post_rst_g0");
    step(0, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, TA, "post_after");
    step(0, 3'b000, S_RR, D_RR, 4'hF, 4'h0, 3'b000, 0, "post_idle");

    @(negedge i_cp);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
